// File: rtl/uart_pkg.sv
// uart_pkg: shared receive-state encoding and oversampling constants.
// Revision 1.0
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int OS_RATE   = 16;
  localparam int MID_LO    = 7;
  localparam int MID_HI    = 9;
  localparam int DATA_BITS = 8;

endpackage

`default_nettype wire

// File: rtl/uart_os_tick_gen.sv
// uart_os_tick_gen: oversample tick, one pulse every max(div,1) clk cycles.
// Revision 1.0
`default_nettype none

module uart_os_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt;
  logic [15:0] last;

  // A zero divisor behaves like 1: tick every cycle.
  assign last = (div == 16'd0) ? 16'd0 : div - 16'd1;
  assign tick = (cnt == last);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= 16'd0;
    end else if (tick) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampled UART receiver with majority vote and valid/ack holding register.
// Revision 1.0
`default_nettype none

module uart_rx_os16 #(
  parameter int OS_RATE   = uart_pkg::OS_RATE,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  input  logic [15:0] baud_rate,
  input  logic        rx_ack,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        parity_bit_error,
  output logic        stop_bit_error,
  output logic        overrun,
  output logic        rx_busy
);

  import uart_pkg::*;

  localparam int SUB_W = $clog2(OS_RATE);
  localparam int BIT_W = $clog2(DATA_BITS);

  state_t               state;
  state_t               state_nxt;
  logic                 sync1;
  logic                 sync2;
  logic                 rxs;
  logic                 rxs_prev;
  logic                 start_det;
  logic [15:0]          div_q;
  logic                 tick;
  logic [SUB_W-1:0]     sub;
  logic [SUB_W-1:0]     sub_idx;
  logic                 at_hi;
  logic                 samp_lo;
  logic                 samp_mid;
  logic                 vote;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 done;

  assign rxs = sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx_in;
      sync2    <= sync1;
      rxs_prev <= sync2;
    end
  end

  assign start_det = (state == IDLE) && rxs_prev && !rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= 16'd1;
    end else if (start_det) begin
      div_q <= (baud_rate == 16'd0) ? 16'd1 : baud_rate;
    end
  end

  uart_os_tick_gen u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_det),
    .div  (div_q),
    .tick (tick)
  );

  // sub holds the previous sub-tick; the tick now being taken is sub+1, so the
  // first tick after start detection is sub-tick 1 of the start bit.
  assign sub_idx = sub + SUB_W'(1);
  assign at_hi   = tick && (sub_idx == SUB_W'(MID_HI));
  assign vote    = (samp_lo & samp_mid) | (samp_lo & rxs) | (samp_mid & rxs);
  assign done    = (state == STOP) && at_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_det) state_nxt = START;
      START:   if (at_hi) state_nxt = vote ? IDLE : DATA;
      DATA:    if (at_hi && bit_idx == BIT_W'(DATA_BITS - 1))
                 state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY:  if (at_hi) state_nxt = STOP;
      STOP:    if (at_hi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      perr     <= 1'b0;
      samp_lo  <= 1'b1;
      samp_mid <= 1'b1;
    end else begin
      if (start_det) begin
        sub     <= '0;
        bit_idx <= '0;
        perr    <= 1'b0;
      end else if (tick) begin
        sub <= sub_idx;
      end
      if (tick && sub_idx == SUB_W'(MID_LO))     samp_lo  <= rxs;
      if (tick && sub_idx == SUB_W'(MID_LO + 1)) samp_mid <= rxs;
      if (state == DATA && at_hi) begin
        shreg   <= {vote, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BIT_W'(1);
      end
      if (state == PARITY && at_hi) perr <= (^shreg) ^ vote;
    end
  end

  // A same-cycle ack frees the holding register, so the new frame loads cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data          <= 8'd0;
      rx_valid         <= 1'b0;
      parity_bit_error <= 1'b0;
      stop_bit_error   <= 1'b0;
      overrun          <= 1'b0;
      rx_busy          <= 1'b0;
    end else begin
      rx_busy <= (state_nxt != IDLE);
      if (done && (!rx_valid || rx_ack)) begin
        rx_data          <= shreg;
        parity_bit_error <= perr;
        stop_bit_error   <= !vote;
        rx_valid         <= 1'b1;
      end else if (done) begin
        overrun <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
